// File: rtl/ofdm_cp_insert.sv
// ofdm_cp_insert
// Cyclic-prefix inserter for the OFDM transmit chain. One full IFFT symbol is
// collected into a local RAM, then replayed as the last CP_LEN samples followed
// by the whole symbol on an AXI-Stream master. Input is stalled while the
// symbol is being replayed. A 2-entry output stage (output register + skid)
// with credit-based read issue keeps one beat per cycle under a steady
// downstream ready and never drops or repeats a beat under back-pressure.
module ofdm_cp_insert #(
  parameter int NFFT      = 1024,
  parameter int LOG2_NFFT = 10,
  parameter int CP_LEN    = 256,
  parameter int DATA_W    = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              event_tlast_missing,
  output logic              event_tlast_unexpected
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_PREFIX = 2'd1,
    ST_BODY   = 2'd2
  } state_t;

  localparam logic [LOG2_NFFT-1:0] LAST_IDX  = LOG2_NFFT'(NFFT - 1);
  localparam logic [LOG2_NFFT-1:0] CP_BASE   = LOG2_NFFT'(NFFT - CP_LEN);
  localparam logic [LOG2_NFFT-1:0] CP_LAST   = LOG2_NFFT'((CP_LEN == 0) ? 0 : CP_LEN - 1);
  localparam logic [LOG2_NFFT-1:0] IDX_ZERO  = {LOG2_NFFT{1'b0}};
  localparam logic [LOG2_NFFT-1:0] IDX_ONE   = LOG2_NFFT'(1);
  // With no prefix the replay starts directly at the symbol body.
  localparam state_t               FILL_EXIT = (CP_LEN == 0) ? ST_BODY : ST_PREFIX;

  logic [DATA_W-1:0] mem [NFFT];

  state_t              state_q, state_d;
  logic [LOG2_NFFT-1:0] wr_idx_q, wr_idx_d;
  logic [LOG2_NFFT-1:0] rd_cnt_q, rd_cnt_d;
  logic                rd_done_q, rd_done_d;
  logic                s_tready_q, s_tready_d;
  logic                ev_missing_q, ev_missing_d;
  logic                ev_unexp_q, ev_unexp_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_last_q, rd_last_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                skid_valid_q, skid_valid_d;
  logic                skid_last_q, skid_last_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;

  logic                in_acc_s;
  logic                pop_s;
  logic                issue_s;
  logic [1:0]          load_s;
  logic [LOG2_NFFT-1:0] rd_addr_s;
  logic                rd_last_s;

  assign in_acc_s = s_axis_tvalid && s_tready_q && (state_q == ST_FILL);
  assign pop_s    = out_valid_q && m_axis_tready;
  // Beats already committed to the output stage: held in out/skid or in flight from the RAM.
  assign load_s   = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_valid_q};
  // A new fetch is allowed only if it is guaranteed a slot when it lands next cycle.
  assign issue_s  = (state_q != ST_FILL) && !rd_done_q && (load_s <= (pop_s ? 2'd2 : 2'd1));

  // Frame sequencing: fill counter, replay address generation, tlast checks
  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    rd_cnt_d     = rd_cnt_q;
    rd_done_d    = rd_done_q;
    s_tready_d   = s_tready_q;
    ev_missing_d = 1'b0;
    ev_unexp_d   = 1'b0;
    rd_addr_s    = rd_cnt_q;
    rd_last_s    = 1'b0;
    case (state_q)
      ST_FILL: begin
        s_tready_d = 1'b1;
        if (in_acc_s) begin
          if (wr_idx_q == LAST_IDX) begin
            ev_missing_d = !s_axis_tlast;
            wr_idx_d     = IDX_ZERO;
            rd_cnt_d     = IDX_ZERO;
            rd_done_d    = 1'b0;
            s_tready_d   = 1'b0;
            state_d      = FILL_EXIT;
          end else begin
            ev_unexp_d = s_axis_tlast;
            wr_idx_d   = wr_idx_q + IDX_ONE;
          end
        end else begin
          wr_idx_d = wr_idx_q;
        end
      end
      ST_PREFIX: begin
        rd_addr_s = CP_BASE + rd_cnt_q;
        if (issue_s) begin
          if (rd_cnt_q == CP_LAST) begin
            rd_cnt_d = IDX_ZERO;
            state_d  = ST_BODY;
          end else begin
            rd_cnt_d = rd_cnt_q + IDX_ONE;
          end
        end else begin
          rd_cnt_d = rd_cnt_q;
        end
      end
      ST_BODY: begin
        rd_addr_s = rd_cnt_q;
        rd_last_s = (rd_cnt_q == LAST_IDX);
        if (issue_s) begin
          if (rd_last_s) begin
            rd_done_d = 1'b1;
          end else begin
            rd_cnt_d = rd_cnt_q + IDX_ONE;
          end
        end else begin
          rd_cnt_d = rd_cnt_q;
        end
        // Input reopens only once the final body beat has left the block.
        if (pop_s && out_last_q) begin
          state_d    = ST_FILL;
          s_tready_d = 1'b1;
          rd_done_d  = 1'b0;
          rd_cnt_d   = IDX_ZERO;
        end else begin
          state_d = ST_BODY;
        end
      end
      default: begin
        state_d    = ST_FILL;
        s_tready_d = 1'b0;
      end
    endcase
  end

  // Output stage: output register refilled from skid first, then from the RAM read
  always_comb begin
    rd_valid_d   = issue_s;
    rd_last_d    = issue_s && rd_last_s;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || pop_s) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_last_d   = skid_last_q;
        out_data_d   = skid_data_q;
        skid_valid_d = rd_valid_q;
        skid_last_d  = rd_last_q;
        skid_data_d  = rd_data_q;
      end else begin
        out_valid_d  = rd_valid_q;
        out_last_d   = rd_valid_q && rd_last_q;
        out_data_d   = rd_valid_q ? rd_data_q : out_data_q;
        skid_valid_d = 1'b0;
      end
    end else begin
      if (rd_valid_q) begin
        skid_valid_d = 1'b1;
        skid_last_d  = rd_last_q;
        skid_data_d  = rd_data_q;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
  end

  // Sample RAM: write on accepted input beats, registered read on each issued fetch
  always_ff @(posedge aclk) begin
    if (in_acc_s) begin
      mem[wr_idx_q] <= s_axis_tdata;
    end
    if (issue_s) begin
      rd_data_q <= mem[rd_addr_s];
    end
  end

  // Control and output registers; reset clears every output and discards the frame
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= ST_FILL;
      wr_idx_q     <= IDX_ZERO;
      rd_cnt_q     <= IDX_ZERO;
      rd_done_q    <= 1'b0;
      s_tready_q   <= 1'b0;
      ev_missing_q <= 1'b0;
      ev_unexp_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= {DATA_W{1'b0}};
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_done_q    <= rd_done_d;
      s_tready_q   <= s_tready_d;
      ev_missing_q <= ev_missing_d;
      ev_unexp_q   <= ev_unexp_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign s_axis_tready          = s_tready_q;
  assign m_axis_tdata           = out_data_q;
  assign m_axis_tvalid          = out_valid_q;
  assign m_axis_tlast           = out_last_q;
  assign event_tlast_missing    = ev_missing_q;
  assign event_tlast_unexpected = ev_unexp_q;

endmodule

// File: tb/tb_ofdm_cp_insert.sv
// tb_ofdm_cp_insert
// Two instances share one stimulus/check engine: dut_a (NFFT=1024, CP=256) and
// dut_b (NFFT=1024, CP=0). A select signal routes input valid and output
// observation to one of them. Expected output is built from the symbol words
// by the prefix rule: last CP samples, then the whole symbol, tlast on the end.
module tb_ofdm_cp_insert;

  localparam int NFFT = 1024;
  localparam int LOG2 = 10;
  localparam int CP   = 256;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  logic          sel = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          m_ready = 1'b0;

  logic          a_s_valid, b_s_valid;
  logic          a_s_ready, b_s_ready;
  logic [DW-1:0] a_m_data, b_m_data;
  logic          a_m_valid, b_m_valid, a_m_last, b_m_last;
  logic          a_ev_miss, b_ev_miss, a_ev_unexp, b_ev_unexp;

  logic          s_ready, m_valid, m_last, ev_miss, ev_unexp;
  logic [DW-1:0] m_data;

  assign a_s_valid = s_valid && !sel;
  assign b_s_valid = s_valid && sel;
  assign s_ready   = sel ? b_s_ready  : a_s_ready;
  assign m_valid   = sel ? b_m_valid  : a_m_valid;
  assign m_data    = sel ? b_m_data   : a_m_data;
  assign m_last    = sel ? b_m_last   : a_m_last;
  assign ev_miss   = sel ? b_ev_miss  : a_ev_miss;
  assign ev_unexp  = sel ? b_ev_unexp : a_ev_unexp;

  ofdm_cp_insert #(.NFFT(NFFT), .LOG2_NFFT(LOG2), .CP_LEN(CP), .DATA_W(DW)) dut_a (
    .aclk(clk), .areset(areset),
    .s_axis_tdata(s_data), .s_axis_tvalid(a_s_valid), .s_axis_tready(a_s_ready), .s_axis_tlast(s_last),
    .m_axis_tdata(a_m_data), .m_axis_tvalid(a_m_valid), .m_axis_tready(m_ready), .m_axis_tlast(a_m_last),
    .event_tlast_missing(a_ev_miss), .event_tlast_unexpected(a_ev_unexp)
  );

  ofdm_cp_insert #(.NFFT(NFFT), .LOG2_NFFT(LOG2), .CP_LEN(0), .DATA_W(DW)) dut_b (
    .aclk(clk), .areset(areset),
    .s_axis_tdata(s_data), .s_axis_tvalid(b_s_valid), .s_axis_tready(b_s_ready), .s_axis_tlast(s_last),
    .m_axis_tdata(b_m_data), .m_axis_tvalid(b_m_valid), .m_axis_tready(m_ready), .m_axis_tlast(b_m_last),
    .event_tlast_missing(b_ev_miss), .event_tlast_unexpected(b_ev_unexp)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Drive nsym symbols into the selected instance and check everything it emits.
  // stop_beat >= 0 returns as soon as that many output beats have been consumed.
  task automatic run_frames(input bit sel_i, input int nsym, input bit rnd_rdy, input bit rnd_vld,
                            input bit bad_tlast, input bit rnd_data, input int stop_beat, input string tag);
    int cp;
    logic [DW-1:0] cur [NFFT];
    logic [DW-1:0] exp_d [$];
    bit exp_l [$];
    int in_idx, sym_in, sym_out, out_cnt, since, waited, limit, p_idx;
    bit busy, first_seen, p_acc, p_last, p_mv, p_mr, done, el, exp_u, exp_m;
    logic [DW-1:0] p_md, ed;
    logic p_ml;

    sel = sel_i;
    cp = sel_i ? 0 : CP;
    for (int k = 0; k < NFFT; k++) cur[k] = rnd_data ? DW'($urandom) : DW'(k);
    in_idx = 0; sym_in = 0; sym_out = 0; out_cnt = 0; since = 0;
    busy = 1'b0; first_seen = 1'b1; p_acc = 1'b0; p_last = 1'b0; p_idx = 0;
    p_mv = 1'b0; p_mr = 1'b0; p_md = '0; p_ml = 1'b0; done = 1'b0;
    s_valid = 1'b0; m_ready = 1'b1;

    waited = 0;
    @(negedge clk);
    while (!s_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s tready_wait: s_axis_tready=%b required 1", tag, s_ready);
    end

    limit = nsym * 6000 + 200;
    for (int cyc = 0; cyc < limit && !done; cyc++) begin
      s_valid = (sym_in < nsym) && (!rnd_vld || $urandom_range(3) != 0);
      s_data  = cur[in_idx];
      s_last  = bad_tlast ? (in_idx == 500) : (in_idx == NFFT - 1);
      m_ready = !rnd_rdy || ($urandom_range(1) == 1);
      #1;

      exp_u = p_acc && p_last && (p_idx != NFFT - 1);
      exp_m = p_acc && !p_last && (p_idx == NFFT - 1);
      n_cmp++;
      if (ev_unexp !== exp_u) begin
        n_err++;
        $display("FAIL %s ev_unexpected cyc %0d: got %b required %b", tag, cyc, ev_unexp, exp_u);
      end
      n_cmp++;
      if (ev_miss !== exp_m) begin
        n_err++;
        $display("FAIL %s ev_missing cyc %0d: got %b required %b", tag, cyc, ev_miss, exp_m);
      end
      n_cmp++;
      if (s_ready !== !busy) begin
        n_err++;
        $display("FAIL %s s_tready cyc %0d: got %b required %b", tag, cyc, s_ready, !busy);
      end
      if (p_mv && !p_mr) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== p_md || m_last !== p_ml) begin
          n_err++;
          $display("FAIL %s stall_hold cyc %0d: valid=%b data=%h last=%b required 1 %h %b",
                   tag, cyc, m_valid, m_data, m_last, p_md, p_ml);
        end
      end
      if (!first_seen) begin
        since++;
        if (m_valid === 1'b1) begin
          first_seen = 1'b1;
          n_cmp++;
          if (since != 3) begin
            n_err++;
            $display("FAIL %s latency: first m_tvalid %0d cycles after last input beat, required 2", tag, since - 1);
          end
        end
      end

      if (m_valid === 1'b1 && m_ready) begin
        n_cmp++;
        if (exp_d.size() == 0) begin
          n_err++;
          $display("FAIL %s extra_beat %0d: data=%h required no beat", tag, out_cnt, m_data);
        end else begin
          ed = exp_d.pop_front();
          el = exp_l.pop_front();
          if (m_data !== ed || m_last !== el) begin
            n_err++;
            $display("FAIL %s beat %0d: data=%h last=%b required data=%h last=%b", tag, out_cnt, m_data, m_last, ed, el);
          end
          if (el) begin
            sym_out++;
            busy = 1'b0;
          end
        end
        out_cnt++;
      end

      p_acc = 1'b0;
      if (s_valid && s_ready === 1'b1) begin
        p_acc = 1'b1;
        p_last = s_last;
        p_idx = in_idx;
        if (in_idx == NFFT - 1) begin
          for (int i = 0; i < cp; i++) begin
            exp_d.push_back(cur[NFFT - cp + i]);
            exp_l.push_back(1'b0);
          end
          for (int i = 0; i < NFFT; i++) begin
            exp_d.push_back(cur[i]);
            exp_l.push_back(i == NFFT - 1);
          end
          sym_in++;
          busy = 1'b1;
          since = 0;
          first_seen = 1'b0;
          in_idx = 0;
          for (int k = 0; k < NFFT; k++) cur[k] = DW'($urandom);
        end else begin
          in_idx++;
        end
      end

      p_mv = (m_valid === 1'b1);
      p_mr = m_ready;
      p_md = m_data;
      p_ml = m_last;
      if (stop_beat >= 0 && out_cnt == stop_beat) return;
      done = (sym_out == nsym);
      @(negedge clk);
    end

    s_valid = 1'b0;
    n_cmp++;
    if (!done || out_cnt != nsym * (NFFT + cp) || exp_d.size() != 0) begin
      n_err++;
      $display("FAIL %s frame_count: beats=%0d symbols=%0d required beats=%0d symbols=%0d",
               tag, out_cnt, sym_out, nsym * (NFFT + cp), nsym);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b0) begin
        n_err++;
        $display("FAIL %s idle_after: m_tvalid=%b required 0", tag, m_valid);
      end
    end
  endtask

  // All outputs of the selected instance must read zero while reset is held.
  task automatic check_outputs_zero(input string tag);
    n_cmp++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0 || s_ready !== 1'b0 ||
        ev_miss !== 1'b0 || ev_unexp !== 1'b0) begin
      n_err++;
      $display("FAIL %s outputs_in_reset: valid=%b last=%b data=%h tready=%b miss=%b unexp=%b required all 0",
               tag, m_valid, m_last, m_data, s_ready, ev_miss, ev_unexp);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(negedge clk);
    sel = 1'b0; #1;
    check_outputs_zero("reset_a");
    sel = 1'b1; #1;
    check_outputs_zero("reset_b");
    @(negedge clk);
    areset = 1'b0;
  endtask

  task automatic test_basic();
    run_frames(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1, "T1_basic");
  endtask

  task automatic test_stall();
    run_frames(1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1, -1, "T2_stall");
  endtask

  task automatic test_tlast_errors();
    run_frames(1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b1, -1, "T3_tlast");
  endtask

  task automatic test_back_to_back();
    run_frames(1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1, -1, "T4_b2b");
  endtask

  task automatic test_reset_mid();
    run_frames(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 100, "T5_pre");
    s_valid = 1'b0;
    areset = 1'b1;
    #1;
    check_outputs_zero("T5_async");
    repeat (2) @(negedge clk);
    check_outputs_zero("T5_held");
    areset = 1'b0;
    run_frames(1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b1, -1, "T5_after");
  endtask

  task automatic test_no_prefix();
    run_frames(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1, "T6_cp0");
    run_frames(1'b1, 2, 1'b1, 1'b1, 1'b0, 1'b1, -1, "T6_cp0_rand");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_tlast_errors();
    test_back_to_back();
    test_reset_mid();
    test_no_prefix();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
